// File: rtl/floor_req_pkg.sv
// Shared types and width helpers for the floor call register and scheduler.
// Provides FLOOR_W/CNT_W helpers, a floor index type and the request bundle.
package floor_req_pkg;

    localparam int FLOORS_DEF = 8;

    // Width of a floor index; never narrower than one bit.
    function automatic int floor_w(input int floors);
        return (floors < 2) ? 1 : $clog2(floors);
    endfunction

    // Width able to hold a count of all 3*floors-2 request bits.
    function automatic int cnt_w(input int floors);
        return $clog2(3 * floors - 1);
    endfunction

    typedef logic [floor_w(FLOORS_DEF)-1:0] floor_idx_t;

    // Hall-up has no top bit, hall-down has no bottom bit.
    typedef struct packed {
        logic [FLOORS_DEF-1:0] cab;
        logic [FLOORS_DEF-2:0] up;
        logic [FLOORS_DEF-1:1] dn;
    } req_vec_t;

endpackage

// File: rtl/floor_request_latch_debounce.sv
// btn_debounce: 2-FF synchroniser plus tick-sampled debouncer for one button.
// Ports: clk, reset (sync, active-high), tick, raw -> level, press (1-cycle rise).
module btn_debounce
    import floor_req_pkg::*;
#(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int RUN_W = $clog2(DEB_SAMPLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_SAMPLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [RUN_W-1:0] run;
    logic             differ;
    logic             flip;

    assign differ = sync_b != level;
    // Last agreeing sample of a full run: the debounced level flips now.
    assign flip   = tick && differ && (run == RUN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            run    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= flip && sync_b;
            if (tick) begin
                if (!differ) begin
                    run <= '0;
                end else if (run == RUN_LAST) begin
                    run   <= '0;
                    level <= sync_b;
                end else begin
                    run <= run + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/floor_request_latch.sv
// floor_request_latch: debounced cabin/hall call register with floor summaries.
// Ports: btn_*/clr_* in, cur_floor in; req_* out, req_here/above/below,
// pending_cnt. Macro FLOOR_REQ_CANCEL_EN: second cabin press cancels the call.
module floor_request_latch
    import floor_req_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int DEB_CYCLES  = 1000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FLOORS-1:0]           btn_cab,
    input  logic [FLOORS-2:0]           btn_up,
    input  logic [FLOORS-1:1]           btn_dn,
    input  logic [FLOORS-1:0]           clr_cab,
    input  logic [FLOORS-2:0]           clr_up,
    input  logic [FLOORS-1:1]           clr_dn,
    input  logic [floor_w(FLOORS)-1:0]  cur_floor,
    output logic [FLOORS-1:0]           req_cab,
    output logic [FLOORS-2:0]           req_up,
    output logic [FLOORS-1:1]           req_dn,
    output logic                        req_here,
    output logic                        req_above,
    output logic                        req_below,
    output logic [cnt_w(FLOORS)-1:0]    pending_cnt
);

    localparam int CNT_W  = cnt_w(FLOORS);
    localparam int TICK_W = $clog2(DEB_CYCLES);

    // Shared debounce sample tick.
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = tick_cnt == TICK_W'(DEB_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    logic [FLOORS-1:0] lvl_cab;
    logic [FLOORS-1:0] prs_cab;
    logic [FLOORS-2:0] lvl_up;
    logic [FLOORS-2:0] prs_up;
    logic [FLOORS-1:1] lvl_dn;
    logic [FLOORS-1:1] prs_dn;

    genvar g;
    for (g = 0; g < FLOORS; g++) begin : g_cab
        btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_cab[g]),
            .level (lvl_cab[g]),
            .press (prs_cab[g])
        );
    end

    for (g = 0; g < FLOORS - 1; g++) begin : g_up
        btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_up[g]),
            .level (lvl_up[g]),
            .press (prs_up[g])
        );
    end

    for (g = 1; g < FLOORS; g++) begin : g_dn
        btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_dn[g]),
            .level (lvl_dn[g]),
            .press (prs_dn[g])
        );
    end

    // A press pulse always coincides with a high debounced level.
    logic [FLOORS-1:0] set_cab;
    logic [FLOORS-2:0] set_up;
    logic [FLOORS-1:1] set_dn;

    assign set_cab = prs_cab & lvl_cab;
    assign set_up  = prs_up & lvl_up;
    assign set_dn  = prs_dn & lvl_dn;

    // Clear has priority over a same-cycle press.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_cab <= '0;
            req_up  <= '0;
            req_dn  <= '0;
        end else begin
            for (int f = 0; f < FLOORS; f++) begin
                if (clr_cab[f]) begin
                    req_cab[f] <= 1'b0;
                end else if (set_cab[f]) begin
`ifdef FLOOR_REQ_CANCEL_EN
                    req_cab[f] <= ~req_cab[f];
`else
                    req_cab[f] <= 1'b1;
`endif
                end
            end
            for (int f = 0; f < FLOORS - 1; f++) begin
                if (clr_up[f]) begin
                    req_up[f] <= 1'b0;
                end else if (set_up[f]) begin
                    req_up[f] <= 1'b1;
                end
            end
            for (int f = 1; f < FLOORS; f++) begin
                if (clr_dn[f]) begin
                    req_dn[f] <= 1'b0;
                end else if (set_dn[f]) begin
                    req_dn[f] <= 1'b1;
                end
            end
        end
    end

    // Per-floor OR; missing hall bits at the ends read as 0.
    logic [FLOORS-1:0] any_req;

    assign any_req = req_cab | {1'b0, req_up} | {req_dn, 1'b0};

    logic             here_d;
    logic             above_d;
    logic             below_d;
    logic [CNT_W-1:0] cnt_d;
    int               cf;

    always_comb begin
        here_d  = 1'b0;
        above_d = 1'b0;
        below_d = 1'b0;
        cnt_d   = '0;
        cf      = int'(cur_floor);
        if (cf < FLOORS) begin
            for (int f = 0; f < FLOORS; f++) begin
                if (f == cf) begin
                    here_d = here_d | any_req[f];
                end else if (f > cf) begin
                    above_d = above_d | any_req[f];
                end else begin
                    below_d = below_d | any_req[f];
                end
            end
        end
        for (int f = 0; f < FLOORS; f++) begin
            cnt_d = cnt_d + CNT_W'(req_cab[f]);
        end
        for (int f = 0; f < FLOORS - 1; f++) begin
            cnt_d = cnt_d + CNT_W'(req_up[f]);
        end
        for (int f = 1; f < FLOORS; f++) begin
            cnt_d = cnt_d + CNT_W'(req_dn[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_here    <= 1'b0;
            req_above   <= 1'b0;
            req_below   <= 1'b0;
            pending_cnt <= '0;
        end else begin
            req_here    <= here_d;
            req_above   <= above_d;
            req_below   <= below_d;
            pending_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_floor_request_latch.sv
// Self-checking bench for floor_request_latch (FLOORS=4, DEB_CYCLES=4,
// DEB_SAMPLES=2): directed scenarios plus random stimulus vs a reference model.
module tb_floor_request_latch;

    localparam int FLOORS      = 4;
    localparam int DEB_CYCLES  = 4;
    localparam int DEB_SAMPLES = 2;
    localparam int NB          = 3 * FLOORS - 2;
`ifdef FLOOR_REQ_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_cab, clr_cab, req_cab;
    logic [2:0] btn_up, clr_up, req_up;
    logic [3:1] btn_dn, clr_dn, req_dn;
    logic [1:0] cur_floor;
    logic       req_here, req_above, req_below;
    logic [3:0] pending_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    floor_request_latch #(
        .FLOORS      (FLOORS),
        .DEB_CYCLES  (DEB_CYCLES),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_cab     (btn_cab),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .clr_cab     (clr_cab),
        .clr_up      (clr_up),
        .clr_dn      (clr_dn),
        .cur_floor   (cur_floor),
        .req_cab     (req_cab),
        .req_up      (req_up),
        .req_dn      (req_dn),
        .req_here    (req_here),
        .req_above   (req_above),
        .req_below   (req_below),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: bit index cab f -> f, up f -> 4+f, dn f -> 6+f.
    logic [NB-1:0] m_req, m_lvl, m_press;
    logic          m_here, m_above, m_below;
    int            m_cnt;
    int            m_n;
    logic [NB-1:0] raw_hist[$];
    logic [NB-1:0] samp_hist[$];

    task automatic model_edge();
        logic [NB-1:0] rv, cv, synced, nxt;
        logic [3:0]    anyf;
        int            cf;
        bit            all_eq;
        rv = {btn_dn, btn_up, btn_cab};
        cv = {clr_dn, clr_up, clr_cab};
        if (reset) begin
            m_req = '0; m_lvl = '0; m_press = '0;
            m_here = 0; m_above = 0; m_below = 0;
            m_cnt = 0; m_n = 0;
            raw_hist.delete();
            samp_hist.delete();
            return;
        end
        for (int f = 0; f < FLOORS; f++) begin
            anyf[f] = m_req[f] | ((f < FLOORS - 1) ? m_req[4+f] : 1'b0)
                    | ((f > 0) ? m_req[6+f] : 1'b0);
        end
        cf = int'(cur_floor);
        m_here = 0; m_above = 0; m_below = 0;
        if (cf < FLOORS) begin
            m_here = anyf[cf];
            for (int f = 0; f < FLOORS; f++) begin
                if (f > cf) m_above = m_above | anyf[f];
                if (f < cf) m_below = m_below | anyf[f];
            end
        end
        m_cnt = $countones(m_req);
        for (int b = 0; b < NB; b++) begin
            if (cv[b]) m_req[b] = 1'b0;
            else if (m_press[b]) m_req[b] = (b < FLOORS && CANCEL) ? ~m_req[b] : 1'b1;
        end
        m_n++;
        synced = (raw_hist.size() >= 2) ? raw_hist[1] : '0;
        raw_hist.push_front(rv);
        if (raw_hist.size() > 2) void'(raw_hist.pop_back());
        nxt = '0;
        if (m_n % DEB_CYCLES == 0) begin
            samp_hist.push_front(synced);
            if (samp_hist.size() > DEB_SAMPLES) void'(samp_hist.pop_back());
            if (samp_hist.size() == DEB_SAMPLES) begin
                for (int b = 0; b < NB; b++) begin
                    all_eq = 1;
                    for (int k = 0; k < DEB_SAMPLES; k++)
                        if (samp_hist[k][b] !== synced[b]) all_eq = 0;
                    if (all_eq && synced[b] !== m_lvl[b]) begin
                        m_lvl[b] = synced[b];
                        nxt[b]   = synced[b];
                    end
                end
            end
        end
        m_press = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        btn_cab = '0; btn_up = '0; btn_dn = '0;
        clr_cab = '0; clr_up = '0; clr_dn = '0;
        cur_floor = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_cab = 4'($urandom); btn_up = 3'($urandom); btn_dn = 3'($urandom);
        cur_floor = 2'($urandom);
        step();
        step();
        n_checks++;
        if ({req_cab, req_up, req_dn, req_here, req_above, req_below, pending_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cab=%b up=%b dn=%b h/a/b=%b%b%b cnt=%0d, want all 0",
                     req_cab, req_up, req_dn, req_here, req_above, req_below, pending_cnt);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_cab_hold();
        int lat;
        bit found;
        do_reset();
        repeat (10) step();
        btn_cab[2] = 1'b1;
        lat = 0; found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_cab !== 4'b0000) begin
                found = 1; lat = c;
            end
        end
        n_checks++;
        if (!found || lat < 8 || lat > 11 || req_cab !== 4'b0100) begin
            n_fail++;
            $display("FAIL cab_latency: got %0d cycles req_cab=%b, want 8..11 and 0100", lat, req_cab);
        end
        n_checks++;
        if (pending_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_lag: got %0d, want 0", pending_cnt);
        end
        step();
        n_checks++;
        if (pending_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL cnt_one: got %0d, want 1", pending_cnt);
        end
        btn_cab[2] = 1'b0;
        repeat (16) step();
        n_checks++;
        if (req_cab !== 4'b0100 || pending_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL cab_release: got %b cnt=%0d, want 0100 cnt=1", req_cab, pending_cnt);
        end
    endtask

    task automatic test_short_pulse();
        bit bad;
        do_reset();
        repeat (5) step();
        btn_up[0] = 1'b1;
        repeat (3) step();
        btn_up[0] = 1'b0;
        bad = 0;
        repeat (20) begin
            step();
            if (req_up !== 3'b000) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL short_pulse: got req_up=%b at some cycle, want 000 throughout", req_up);
        end
    endtask

    task automatic test_glitch();
        bit bad, found;
        int lat;
        do_reset();
        repeat (3) step();
        bad = 0;
        btn_up[1] = 1'b1;
        repeat (4) begin step(); if (req_up !== 3'b000) bad = 1; end
        btn_up[1] = 1'b0;
        repeat (4) begin step(); if (req_up !== 3'b000) bad = 1; end
        btn_up[1] = 1'b1;
        found = 0; lat = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_up !== 3'b000) begin found = 1; lat = c; end
        end
        n_checks++;
        if (bad || !found || lat < 8 || lat > 11 || req_up !== 3'b010) begin
            n_fail++;
            $display("FAIL glitch_set: got early=%0b lat=%0d req_up=%b, want no early, 8..11, 010",
                     bad, lat, req_up);
        end
        clr_up[1] = 1'b1;
        step();
        clr_up[1] = 1'b0;
        bad = 0;
        repeat (20) begin step(); if (req_up[1] !== 1'b0) bad = 1; end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL glitch_single: got req_up[1]=1 again while held, want 0");
        end
        btn_up[1] = 1'b0;
    endtask

    task automatic test_clear();
        bit found, bad;
        do_reset();
        btn_dn[3] = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_dn[3] === 1'b1) found = 1;
        end
        step();
        n_checks++;
        if (!found || pending_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL dn_set: got found=%0b cnt=%0d, want 1 and 1", found, pending_cnt);
        end
        clr_dn[3] = 1'b1;
        step();
        n_checks++;
        if (req_dn[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_next: got req_dn[3]=%b, want 0", req_dn[3]);
        end
        step();
        n_checks++;
        if (pending_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_cnt: got %0d, want 0", pending_cnt);
        end
        bad = 0;
        btn_dn[3] = 1'b0;
        repeat (14) begin step(); if (req_dn[3] !== 1'b0) bad = 1; end
        btn_dn[3] = 1'b1;
        repeat (14) begin step(); if (req_dn[3] !== 1'b0) bad = 1; end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL clr_hold: got req_dn[3]=1 during clear, want 0");
        end
        clr_dn[3] = 1'b0;
        bad = 0;
        repeat (15) begin step(); if (req_dn[3] !== 1'b0) bad = 1; end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL clr_discard: got req_dn[3]=1 after clear, want 0");
        end
        btn_dn[3] = 1'b0;
    endtask

    task automatic test_summary();
        bit found;
        do_reset();
        btn_cab[3] = 1'b1;
        btn_up[0]  = 1'b1;
        cur_floor  = 2'd1;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_cab[3] === 1'b1 && req_up[0] === 1'b1) found = 1;
        end
        btn_cab[3] = 1'b0;
        btn_up[0]  = 1'b0;
        step();
        n_checks++;
        if (!found || {req_here, req_above, req_below} !== 3'b011 || pending_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL sum_floor1: got h/a/b=%b%b%b cnt=%0d, want 011 cnt=2",
                     req_here, req_above, req_below, pending_cnt);
        end
        cur_floor = 2'd3;
        step();
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b101) begin
            n_fail++;
            $display("FAIL sum_floor3: got h/a/b=%b%b%b, want 101", req_here, req_above, req_below);
        end
        cur_floor = 2'd0;
        step();
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b110) begin
            n_fail++;
            $display("FAIL sum_floor0: got h/a/b=%b%b%b, want 110", req_here, req_above, req_below);
        end
    endtask

    task automatic test_cancel();
        bit found;
        do_reset();
        btn_cab[1] = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_cab[1] === 1'b1) found = 1;
        end
        btn_cab[1] = 1'b0;
        repeat (16) step();
        btn_cab[1] = 1'b1;
        repeat (16) step();
        n_checks++;
        if (!found || req_cab[1] !== !CANCEL) begin
            n_fail++;
            $display("FAIL cab_second_press: got first=%0b req_cab[1]=%b, want 1 then %b",
                     found, req_cab[1], !CANCEL);
        end
        btn_cab[1] = 1'b0;
        repeat (16) step();
    endtask

    task automatic test_reset_mid();
        bit found;
        int lat;
        do_reset();
        btn_cab[0] = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_cab[0] === 1'b1) found = 1;
        end
        btn_dn[2] = 1'b1;
        cur_floor = 2'd2;
        repeat (5) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (!found || {req_cab, req_up, req_dn, req_here, req_above, req_below, pending_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got found=%0b cab=%b dn=%b cnt=%0d, want all 0",
                     found, req_cab, req_dn, pending_cnt);
        end
        reset = 1'b0;
        found = 0; lat = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (req_dn[2] === 1'b1) begin found = 1; lat = c; end
        end
        n_checks++;
        if (!found || lat < 8 || lat > 11) begin
            n_fail++;
            $display("FAIL held_through_reset: got lat=%0d found=%0b, want 8..11", lat, found);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [NB-1:0] dr;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < FLOORS; b++) begin
                if ($urandom_range(11) == 0) btn_cab[b] = ~btn_cab[b];
                clr_cab[b] = ($urandom_range(39) == 0);
            end
            for (int b = 0; b < FLOORS - 1; b++) begin
                if ($urandom_range(11) == 0) btn_up[b] = ~btn_up[b];
                clr_up[b] = ($urandom_range(39) == 0);
                if ($urandom_range(11) == 0) btn_dn[b+1] = ~btn_dn[b+1];
                clr_dn[b+1] = ($urandom_range(39) == 0);
            end
            if ($urandom_range(7) == 0) cur_floor = 2'($urandom);
            reset = ($urandom_range(299) == 0);
            step();
            dr = {req_dn, req_up, req_cab};
            n_checks++;
            if (dr !== m_req || req_here !== m_here || req_above !== m_above
                || req_below !== m_below || int'(pending_cnt) != m_cnt) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got req=%b h/a/b=%b%b%b cnt=%0d, want req=%b h/a/b=%b%b%b cnt=%0d",
                         c, dr, req_here, req_above, req_below, pending_cnt,
                         m_req, m_here, m_above, m_below, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_cab_hold();
        test_short_pulse();
        test_glitch();
        test_clear();
        test_summary();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
